smaesh_key_serializer: RTL and testbench
========================================

# smaesh_key_serializer

Transmitter for the SMAesH core key-loading port. It accepts a complete masked key, meaning all `d` shares in parallel, in one valid/ready transfer. It then streams the key onto the core's 32-bit `in_key_*` interface word by word: share 0 words 0..KWORDS-1 first, then share 1, and so on up to share d-1. It sits between a key-storage or unmasking-free provisioning block and `smaesh_hpc`, replacing software word-by-word key feeding.

## Interface
Parameters:
- `d`, default 2: number of shares (≥2).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  masked key available.
- `in_ready`  out  1  block can capture a key.
- `in_key_shares`  in  256*d  share-major masked key: share i at `[256*i +: 256]`, word k of a share at `[32*k +: 32]` within the share; unused upper words are ignored.
- `in_key_size_cfg`  in  2  `KSIZE_128`/`KSIZE_192`/`KSIZE_256` (encodings from `smaesh_config.vh`).
- `in_mode_inverse`  in  1  key schedule direction for the core.
- `out_key_valid`  out  1  to core `in_key_valid`.
- `out_key_ready`  in  1  from core `in_key_ready`.
- `out_key_data`  out  32  to core `in_key_data`.
- `out_key_size_cfg`  out  2  to core `in_key_size_cfg`.
- `out_key_mode_inverse`  out  1  to core `in_key_mode_inverse`.
- `busy`  out  1  transfer in progress.

## Operation
- FSM with 2 states: IDLE and SEND.
- IDLE: `in_ready`=1. On `in_valid & in_ready`:
  - capture `in_key_shares`, cfg and mode into registers;
  - set KWORDS to 4, 6 or 8 from cfg; any other cfg value gives KWORDS=4;
  - clear word counter `w` and share counter `s`;
  - go to SEND.
- SEND: `out_key_valid`=1 and `out_key_data` = key_reg`[256*s + 32*w +: 32]`.
  - On `out_key_valid & out_key_ready`: increment `w`. At `w`=KWORDS-1, wrap `w` to 0 and increment `s`.
  - The transfer at `s`=d-1, `w`=KWORDS-1 is the last. It returns the FSM to IDLE and clears key_reg to all-zero, so no share residue remains.
- Total transfers per key: d*KWORDS. Words at index ≥KWORDS in each share are never emitted.
- `out_key_size_cfg` and `out_key_mode_inverse` hold the captured values for the whole transfer and until the next capture.
- `in_valid` during SEND is ignored; the producer holds it until IDLE.
- `out_key_data` is 0 in IDLE (key_reg cleared). `busy` = (state==SEND).
- Counters: `w` is 3 bits and `s` is clog2(d) bits (minimum 1); neither exceeds its bound.

## Timing
- Reset (async assert on `rst_n`=0): state IDLE, `in_ready`=1, `out_key_valid`=0, `busy`=0, `out_key_data`=0, `out_key_size_cfg`=0, `out_key_mode_inverse`=0, key_reg=0, counters=0. Outputs change immediately, not at the next edge. Reset mid-transfer abandons the key, and no further words are emitted.
- Capture at edge N: `out_key_valid`=1 and the first word is on `out_key_data` from edge N onward, i.e. the cycle after capture.
- With `out_key_ready` held high: one word per cycle; the last word is transferred at edge N+d*KWORDS; `in_ready`=1 from that edge onward.
- The next key can be captured at edge N+d*KWORDS+1 (one IDLE cycle minimum between keys). `in_ready` is registered state, never combinationally dependent on `out_key_ready`.
- Stall (`out_key_valid & !out_key_ready`): `out_key_data`, cfg and mode remain stable; no counter moves.
- `out_key_valid` never deasserts in SEND before the last transfer.

## Test plan
- d=2, KSIZE_128, share0 words = 0x00010203, 0x04050607, 0x08090a0b, 0x0c0d0e0f, share1 = 0, `out_key_ready`=1, capture at edge N → 8 words on edges N+1..N+8 in order share0 w0..w3, then four zeros; `in_ready`=1 after edge N+8; `out_key_data`=0 afterwards.
- Same key with `out_key_ready` toggling 1,0,1,0,… → exactly 8 handshakes, data stable across every stalled cycle, same word order.
- d=3, KSIZE_256, `in_mode_inverse`=1, share i word k = {i[7:0],k[7:0],16'hA5A5} → 24 transfers in share-major order, `out_key_mode_inverse`=1 and `out_key_size_cfg`=KSIZE_256 on all of them.
- d=2, KSIZE_192 with words 6 and 7 of each share set to 0xDEADBEEF → 12 transfers; 0xDEADBEEF is never emitted.
- `rst_n` pulled low after 3 transfers → `out_key_valid`=0 and `out_key_data`=0 immediately. After release, `in_ready`=1. A new key restarts at share0 w0.
- `in_valid` held high throughout with two different keys queued → second key is ignored during SEND and captured exactly one cycle after the last transfer of the first key; both streams are correct.

Source files
------------

// File: rtl/smaesh_key_serializer.sv
// Streams a parallel d-share masked key onto the SMAesH 32-bit key port,
// share-major, KWORDS words per share, then wipes the captured key.
module smaesh_key_serializer #(
  parameter int unsigned d = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [256*d-1:0] in_key_shares,
  input  logic [1:0]       in_key_size_cfg,
  input  logic             in_mode_inverse,
  output logic             out_key_valid,
  input  logic             out_key_ready,
  output logic [31:0]      out_key_data,
  output logic [1:0]       out_key_size_cfg,
  output logic             out_key_mode_inverse,
  output logic             busy
);

  // Key size encodings shared with the core configuration header.
  localparam logic [1:0] KSIZE_128 = 2'b00;
  localparam logic [1:0] KSIZE_192 = 2'b01;
  localparam logic [1:0] KSIZE_256 = 2'b10;

  localparam int unsigned SW = ($clog2(d) > 1) ? $clog2(d) : 1;
  localparam logic [SW-1:0] SLast = SW'(d - 1);

  typedef enum logic {StIdle, StSend} state_e;

  state_e           state_q, state_d;
  logic [256*d-1:0] key_q, key_d;
  logic [2:0]       w_q, w_d;
  logic [2:0]       w_last_q, w_last_d;
  logic [SW-1:0]    s_q, s_d;
  logic [1:0]       cfg_q, cfg_d;
  logic             mode_q, mode_d;
  logic [31:0]      word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      key_q    <= '0;
      w_q      <= '0;
      w_last_q <= 3'd3;
      s_q      <= '0;
      cfg_q    <= '0;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      w_q      <= w_d;
      w_last_q <= w_last_d;
      s_q      <= s_d;
      cfg_q    <= cfg_d;
      mode_q   <= mode_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    key_d         = key_q;
    w_d           = w_q;
    w_last_d      = w_last_q;
    s_d           = s_q;
    cfg_d         = cfg_q;
    mode_d        = mode_q;
    in_ready      = 1'b0;
    out_key_valid = 1'b0;
    case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          key_d  = in_key_shares;
          cfg_d  = in_key_size_cfg;
          mode_d = in_mode_inverse;
          case (in_key_size_cfg)
            KSIZE_192: w_last_d = 3'd5;
            KSIZE_256: w_last_d = 3'd7;
            KSIZE_128: w_last_d = 3'd3;
            default:   w_last_d = 3'd3;
          endcase
          w_d     = '0;
          s_d     = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        out_key_valid = 1'b1;
        if (out_key_ready) begin
          if (w_q == w_last_q) begin
            w_d = '0;
            if (s_q == SLast) begin
              // Last word of the last share: leave no share residue behind.
              s_d     = '0;
              key_d   = '0;
              state_d = StIdle;
            end else begin
              s_d = s_q + SW'(1);
            end
          end else begin
            w_d = w_q + 3'd1;
          end
        end
      end
    endcase
  end

  // Word mux with constant slices; unused high words are never selected.
  always_comb begin
    word = '0;
    for (int i = 0; i < int'(d); i++) begin
      for (int k = 0; k < 8; k++) begin
        if (s_q == SW'(i) && w_q == 3'(k)) begin
          word = key_q[256*i + 32*k +: 32];
        end
      end
    end
  end

  assign out_key_data         = (state_q == StSend) ? word : 32'h0;
  assign out_key_size_cfg     = cfg_q;
  assign out_key_mode_inverse = mode_q;
  assign busy                 = (state_q == StSend);

endmodule

// File: tb/tb_smaesh_key_serializer.sv
// Directed bench for smaesh_key_serializer with d=2 and d=3 instances.
module tb_smaesh_key_serializer;

  localparam logic [1:0] K128 = 2'b00;
  localparam logic [1:0] K192 = 2'b01;
  localparam logic [1:0] K256 = 2'b10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid2, in_valid3;
  logic         out_key_ready;
  logic [1:0]   cfg;
  logic         mode;
  logic [511:0] shares2;
  logic [767:0] shares3;

  logic         in_ready2, ov2, busy2, omode2;
  logic [31:0]  od2;
  logic [1:0]   ocfg2;
  logic         in_ready3, ov3, busy3, omode3;
  logic [31:0]  od3;
  logic [1:0]   ocfg3;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  smaesh_key_serializer #(.d(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_key_shares(shares2), .in_key_size_cfg(cfg), .in_mode_inverse(mode),
    .out_key_valid(ov2), .out_key_ready(out_key_ready), .out_key_data(od2),
    .out_key_size_cfg(ocfg2), .out_key_mode_inverse(omode2), .busy(busy2)
  );

  smaesh_key_serializer #(.d(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_key_shares(shares3), .in_key_size_cfg(cfg), .in_mode_inverse(mode),
    .out_key_valid(ov3), .out_key_ready(out_key_ready), .out_key_data(od3),
    .out_key_size_cfg(ocfg3), .out_key_mode_inverse(omode3), .busy(busy3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one key into the chosen instance; optionally keep in_valid high afterwards.
  task automatic load(input int which, input logic [1:0] c, input logic m, input bit hold);
    cfg  = c;
    mode = m;
    if (which == 2) in_valid2 = 1'b1; else in_valid3 = 1'b1;
    step();
    if (!hold) begin
      in_valid2 = 1'b0;
      in_valid3 = 1'b0;
    end
  endtask

  // Consume exp_q from the chosen instance, checking every cycle incl. stalls.
  task automatic run(input int which, input bit toggle, input logic [1:0] ecfg, input logic emode);
    int n = exp_q.size();
    int idx = 0;
    int cyc = 0;
    logic r = 1'b1;
    while (idx < n && cyc < 400) begin
      out_key_ready = r;
      check("valid", (which == 2) ? ov2 : ov3, 32'd1);
      check("data", (which == 2) ? od2 : od3, exp_q[idx]);
      check("cfg", (which == 2) ? ocfg2 : ocfg3, ecfg);
      check("mode", (which == 2) ? omode2 : omode3, emode);
      if (r) idx++;
      if (toggle) r = ~r;
      step();
      cyc++;
    end
    check("count", idx, n);
    check("end_valid", (which == 2) ? ov2 : ov3, 32'd0);
    check("end_ready", (which == 2) ? in_ready2 : in_ready3, 32'd1);
    check("end_data", (which == 2) ? od2 : od3, 32'd0);
    check("end_busy", (which == 2) ? busy2 : busy3, 32'd0);
    out_key_ready = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid2 = 1'b0;
    in_valid3 = 1'b0;
    out_key_ready = 1'b0;
    cfg = K128;
    mode = 1'b0;
    shares2 = '0;
    shares3 = '0;
    #1;
    check("rst_in_ready", in_ready2, 32'd1);
    check("rst_valid", ov2, 32'd0);
    check("rst_busy", busy2, 32'd0);
    check("rst_data", od2, 32'd0);
    check("rst_cfg", ocfg2, 32'd0);
    check("rst_mode", omode2, 32'd0);
    check("rst_valid3", ov3, 32'd0);
    #12;
    rst_n = 1'b1;
    step();

    // KSIZE_128, ready held high
    shares2 = {256'h0, 128'h0, 32'h0c0d0e0f, 32'h08090a0b, 32'h04050607, 32'h00010203};
    out_key_ready = 1'b1;
    load(2, K128, 1'b0, 1'b0);
    check("first_word", od2, 32'h00010203);
    check("busy", busy2, 32'd1);
    check("in_ready_send", in_ready2, 32'd0);
    exp_q = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f, 0, 0, 0, 0};
    run(2, 1'b0, K128, 1'b0);

    // Same key, ready toggling
    load(2, K128, 1'b0, 1'b0);
    exp_q = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f, 0, 0, 0, 0};
    run(2, 1'b1, K128, 1'b0);

    // d=3, KSIZE_256, inverse mode
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 8; k++) begin
        shares3[256*i + 32*k +: 32] = {8'(i), 8'(k), 16'hA5A5};
        exp_q.push_back({8'(i), 8'(k), 16'hA5A5});
      end
    end
    load(3, K256, 1'b1, 1'b0);
    run(3, 1'b0, K256, 1'b1);
    check("hold_cfg3", ocfg3, K256);
    check("hold_mode3", omode3, 32'd1);

    // KSIZE_192: words 6 and 7 must never appear
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 8; k++) begin
        shares2[256*i + 32*k +: 32] = (k >= 6) ? 32'hDEADBEEF : ((i + 1) * 32'h10000000 + k);
        if (k < 6) exp_q.push_back((i + 1) * 32'h10000000 + k);
      end
    end
    load(2, K192, 1'b0, 1'b0);
    run(2, 1'b1, K192, 1'b0);

    // Reset mid-transfer after 3 words
    shares2 = {256'h0, 128'h0, 32'h0c0d0e0f, 32'h08090a0b, 32'h04050607, 32'h00010203};
    load(2, K128, 1'b1, 1'b0);
    check("pre_rst_data", od2, 32'h00010203);
    step();
    step();
    step();
    check("mid_data", od2, 32'h0c0d0e0f);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", ov2, 32'd0);
    check("mid_rst_data", od2, 32'd0);
    check("mid_rst_mode", omode2, 32'd0);
    #2;
    rst_n = 1'b1;
    step();
    check("post_rst_ready", in_ready2, 32'd1);
    check("post_rst_valid", ov2, 32'd0);
    load(2, K128, 1'b0, 1'b0);
    exp_q = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f, 0, 0, 0, 0};
    run(2, 1'b0, K128, 1'b0);

    // in_valid held high with a second key queued behind the first
    load(2, K128, 1'b0, 1'b1);
    shares2 = {256'h0, 128'h0, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    exp_q = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f, 0, 0, 0, 0};
    run(2, 1'b0, K128, 1'b0);
    step();
    in_valid2 = 1'b0;
    check("second_capture", ov2, 32'd1);
    exp_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 0, 0, 0, 0};
    run(2, 1'b0, K128, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
